// File: rtl/reg_if_arbiter.sv
// Two-requester arbiter onto a shared register bank.
// One pending slot per requester, alternating tie break, bounded wait.
module reg_if_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        err_clr,
  input  logic [20:0] s0_addr,
  input  logic [15:0] s0_wdata,
  input  logic        s0_valid,
  input  logic        s0_we,
  output logic [15:0] s0_rdata,
  output logic        s0_ready,
  input  logic [20:0] s1_addr,
  input  logic [15:0] s1_wdata,
  input  logic        s1_valid,
  input  logic        s1_we,
  output logic [15:0] s1_rdata,
  output logic        s1_ready,
  output logic [20:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_we,
  output logic        m_valid,
  input  logic [15:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        err_timeout,
  output logic [1:0]  err_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [20:0] addr;
    logic [15:0] wdata;
    logic        we;
  } req_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  req_t        req  [2];
  req_t        slot [2];
  logic [15:0] rdata [2];
  logic [1:0]  valid, pend, cpl, rdy;
  logic [7:0]  cnt;
  logic        gnt, gnt_d, last;
  logic        done, abort, start;

  assign req[0] = {s0_addr, s0_wdata, s0_we};
  assign req[1] = {s1_addr, s1_wdata, s1_we};
  assign valid  = {s1_valid, s0_valid};

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          state_d = ISSUE;
          gnt_d   = (&pend) ? ~last : pend[1];
        end
      end
      ISSUE, WAIT: begin
        if (m_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt == LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including a completion this cycle
    if (!enable) begin
      state_d = IDLE;
      done    = 1'b0;
      abort   = 1'b0;
    end
  end

  assign start = (state == IDLE) && (state_d == ISSUE);
  assign cpl   = !(done | abort) ? 2'b00 :
                 (gnt ? 2'b10 : 2'b01);

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= 1'b0;
      last         <= 1'b1;
      cnt          <= '0;
      rdy          <= '0;
      pend         <= '0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_we         <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= '0;
      for (int n = 0; n < 2; n++) begin
        slot[n]  <= '0;
        rdata[n] <= '0;
      end
    end else begin
      rdy <= '0;
      if (start) begin
        gnt     <= gnt_d;
        m_addr  <= slot[gnt_d].addr;
        m_wdata <= slot[gnt_d].wdata;
        m_we    <= slot[gnt_d].we;
        cnt     <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 8'd1;
      end
      if (done | abort) begin
        rdy[gnt]   <= 1'b1;
        rdata[gnt] <= abort ? 16'hDEAD : m_rdata;
        last       <= gnt;
      end
      if (abort)        err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (!enable) begin
          pend[n] <= 1'b0;
        end else if (valid[n] && (!pend[n] || cpl[n])) begin
          pend[n] <= 1'b1;
          slot[n] <= req[n];
        end else if (cpl[n]) begin
          pend[n] <= 1'b0;
        end
        if (enable && valid[n] && pend[n] && !cpl[n])
          err_overflow[n] <= 1'b1;
        else if (err_clr)
          err_overflow[n] <= 1'b0;
      end
    end
  end

  assign m_valid  = (state == ISSUE) && enable;
  assign busy     = (state != IDLE) || (|pend);
  assign s0_ready = rdy[0];
  assign s1_ready = rdy[1];
  assign s0_rdata = rdata[0];
  assign s1_rdata = rdata[1];

endmodule

// File: tb/tb_reg_if_arbiter.sv
// Directed bench for reg_if_arbiter: reset, transfer, arbitration,
// timeout, overflow, flush, reload and mid-transaction reset.
module tb_reg_if_arbiter;

  localparam int TO = 200;

  logic        clk_25m = 1'b0;
  logic        rst_n, enable, err_clr;
  logic [20:0] s0_addr, s1_addr, m_addr;
  logic [15:0] s0_wdata, s1_wdata, m_wdata;
  logic        s0_valid, s1_valid, s0_we, s1_we;
  logic [15:0] s0_rdata, s1_rdata, m_rdata;
  logic        s0_ready, s1_ready;
  logic        m_we, m_valid, m_ready;
  logic        busy, err_timeout;
  logic [1:0]  err_overflow;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  int r0_cnt = 0;
  int r1_cnt = 0;

  always #20 clk_25m = ~clk_25m;

  reg_if_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk_25m(clk_25m), .rst_n(rst_n),
    .enable(enable), .err_clr(err_clr),
    .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_valid(s0_valid), .s0_we(s0_we),
    .s0_rdata(s0_rdata), .s0_ready(s0_ready),
    .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_valid(s1_valid), .s1_we(s1_we),
    .s1_rdata(s1_rdata), .s1_ready(s1_ready),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_we(m_we), .m_valid(m_valid),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .err_timeout(err_timeout),
    .err_overflow(err_overflow)
  );

  always @(negedge clk_25m) begin
    if (m_valid)  mv_cnt++;
    if (s0_ready) r0_cnt++;
    if (s1_ready) r1_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; err_clr = 1'b0;
    s0_addr = '0; s0_wdata = '0;
    s0_valid = 1'b0; s0_we = 1'b0;
    s1_addr = '0; s1_wdata = '0;
    s1_valid = 1'b0; s1_we = 1'b0;
    m_rdata = '0; m_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Acts as the bank: waits for m_valid, then answers at once.
  task automatic serve(input logic [15:0] rd,
                       output logic [20:0] addr,
                       output logic [1:0] rdy,
                       output logic ok);
    ok = 1'b0; addr = '0; rdy = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_valid) ok = 1'b1;
      else tick();
    end
    if (ok) begin
      addr = m_addr;
      m_rdata = rd; m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      rdy = {s1_ready, s0_ready};
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    m_ready = 1'b1;
    s0_valid = 1'b1;
    rst_n = 1'b0;
    #5;
    tick();
    checks++;
    if ({m_addr, m_wdata, m_we, m_valid} !== '0) begin
      errors++;
      $display("FAIL reset_m got %h %h %b %b exp 0",
               m_addr, m_wdata, m_we, m_valid);
    end
    checks++;
    if ({s0_rdata, s1_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h exp 0",
               s0_rdata, s1_rdata);
    end
    checks++;
    if ({s0_ready, s1_ready, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rdy_busy got %b%b%b exp 000",
               s0_ready, s1_ready, busy);
    end
    checks++;
    if ({err_timeout, err_overflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_err got %b %b exp 0 00",
               err_timeout, err_overflow);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int r0;
    do_reset();
    s0_addr = 21'h01234; s0_we = 1'b0;
    s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_load got busy=%b mv=%b exp 1 0",
               busy, m_valid);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_addr !== 21'h01234 ||
        m_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_issue got mv=%b a=%h we=%b exp 1 01234 0",
               m_valid, m_addr, m_we);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait_mv got %b exp 0", m_valid);
    end
    tick();
    m_rdata = 16'hBEEF; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (s0_ready !== 1'b1 || s0_rdata !== 16'hBEEF ||
        s1_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_resp got r=%b d=%h r1=%b exp 1 beef 0",
               s0_ready, s0_rdata, s1_ready);
    end
    tick();
    checks++;
    if (s0_ready !== 1'b0 || s0_rdata !== 16'hBEEF ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold got r=%b d=%h b=%b exp 0 beef 0",
               s0_ready, s0_rdata, busy);
    end
    r0 = r0_cnt;
    m_rdata = 16'h1111; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    checks++;
    if (r0_cnt !== r0 || s0_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL idle_ready got %0d %h exp %0d beef",
               r0_cnt, s0_rdata, r0);
    end
  endtask

  task automatic test_arb();
    logic [20:0] a;
    logic [1:0]  r;
    logic        ok;
    logic [20:0] exp_a [5];
    logic [1:0]  exp_r [5];
    exp_a = '{21'h00A00, 21'h10B11, 21'h00A00,
              21'h10B11, 21'h00A00};
    exp_r = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    s0_addr = 21'h00A00; s1_addr = 21'h10B11;
    s0_valid = 1'b1; s1_valid = 1'b1;
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        s0_valid = 1'b1; tick(); s0_valid = 1'b0;
      end
      if (k == 3) begin
        s0_valid = 1'b1; s1_valid = 1'b1;
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
      end
      serve(16'h0100 + 16'(k), a, r, ok);
      checks++;
      if (!ok || a !== exp_a[k] || r !== exp_r[k]) begin
        errors++;
        $display("FAIL arb_%0d got ok=%b a=%h r=%b exp 1 %h %b",
                 k, ok, a, r, exp_a[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int mv;
    do_reset();
    mv = mv_cnt;
    s1_addr = 21'h1F0001; s1_wdata = 16'hA5A5;
    s1_we = 1'b1; s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_addr !== 21'h1F0001 ||
        m_wdata !== 16'hA5A5 || m_we !== 1'b1) begin
      errors++;
      $display("FAIL to_issue got %b %h %h %b exp 1 1f0001 a5a5 1",
               m_valid, m_addr, m_wdata, m_we);
    end
    repeat (TO - 1) tick();
    checks++;
    if (s1_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early got r=%b b=%b exp 0 1",
               s1_ready, busy);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (s1_ready !== 1'b1 || s1_rdata !== 16'hDEAD ||
        err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_abort got r=%b d=%h e=%b exp 1 dead 1",
               s1_ready, s1_rdata, err_timeout);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 ||
        mv_cnt - mv !== 1) begin
      errors++;
      $display("FAIL to_sticky got e=%b b=%b mv=%0d exp 1 0 1",
               err_timeout, busy, mv_cnt - mv);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear got %b exp 0", err_timeout);
    end
  endtask

  task automatic test_race();
    do_reset();
    s0_addr = 21'h00042; s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    tick();
    repeat (TO - 1) tick();
    m_rdata = 16'h5A5A; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (s0_ready !== 1'b1 || s0_rdata !== 16'h5A5A ||
        err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL race got r=%b d=%h e=%b exp 1 5a5a 0",
               s0_ready, s0_rdata, err_timeout);
    end
  endtask

  task automatic test_overflow();
    int mv;
    do_reset();
    mv = mv_cnt;
    s0_addr = 21'h00010; s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    tick();
    s0_addr = 21'h00020; s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    checks++;
    if (err_overflow !== 2'b01) begin
      errors++;
      $display("FAIL ovf_set got %b exp 01", err_overflow);
    end
    m_rdata = 16'h1111; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (mv_cnt - mv !== 1 || busy !== 1'b0 ||
        err_overflow !== 2'b01) begin
      errors++;
      $display("FAIL ovf_drop got mv=%0d b=%b o=%b exp 1 0 01",
               mv_cnt - mv, busy, err_overflow);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_overflow !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear got %b exp 00", err_overflow);
    end
  endtask

  task automatic test_flush();
    int r0, mv;
    do_reset();
    r0 = r0_cnt;
    s0_addr = 21'h00333; s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    tick();
    tick();
    mv = mv_cnt;
    enable = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got b=%b mv=%b exp 0 0",
               busy, m_valid);
    end
    m_rdata = 16'h7777; m_ready = 1'b1;
    s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    enable = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (r0_cnt !== r0 || mv_cnt !== mv || busy !== 1'b0 ||
        err_overflow !== 2'b00 || s0_rdata !== 16'h0) begin
      errors++;
      $display("FAIL flush_late got r=%0d mv=%0d b=%b o=%b d=%h",
               r0_cnt - r0, mv_cnt - mv, busy, err_overflow,
               s0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    s0_addr = 21'h00AAA; s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    tick();
    m_rdata = 16'h2222; m_ready = 1'b1;
    s0_addr = 21'h00BBB; s0_valid = 1'b1;
    tick();
    m_ready = 1'b0; s0_valid = 1'b0;
    checks++;
    if (s0_ready !== 1'b1 || busy !== 1'b1 ||
        err_overflow !== 2'b00) begin
      errors++;
      $display("FAIL b2b_cpl got r=%b b=%b o=%b exp 1 1 00",
               s0_ready, busy, err_overflow);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_addr !== 21'h00BBB) begin
      errors++;
      $display("FAIL b2b_issue got mv=%b a=%h exp 1 00bbb",
               m_valid, m_addr);
    end
    m_rdata = 16'h3333; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (s0_ready !== 1'b1 || s0_rdata !== 16'h3333) begin
      errors++;
      $display("FAIL b2b_resp got r=%b d=%h exp 1 3333",
               s0_ready, s0_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    do_reset();
    s0_addr = 21'h00555; s0_valid = 1'b1;
    tick();
    s0_valid = 1'b0;
    tick();
    tick();
    r0 = r0_cnt;
    #10;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 ||
        s0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got b=%b mv=%b r=%b exp 000",
               busy, m_valid, s0_ready);
    end
    m_rdata = 16'h4444; m_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    checks++;
    if (r0_cnt !== r0 || busy !== 1'b0 ||
        s0_rdata !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_resp got r=%0d b=%b d=%h exp 0 0 0",
               r0_cnt - r0, busy, s0_rdata);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_arb();
    test_timeout();
    test_race();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
